// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the core FSM (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, op1, op2,
        input  busy, done, result
    );

    modport slave (
        input  start, func3, op1, op2,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension execute unit: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, fixed latency.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                busy_r;
    logic                done_r;
    logic [XLEN-1:0]     result_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          func3_r;
    logic                neg1_r;
    logic                neg2_r;
    logic                div_zero_r;
    logic [XLEN-1:0]     opa_r;
    logic [XLEN-1:0]     opb_r;
    logic [2*XLEN-1:0]   wide_r;
    logic [2*XLEN-1:0]   prod_r;
    logic [XLEN-1:0]     rem_r;

    logic                op1_signed_s;
    logic                op2_signed_s;
    logic                neg1_s;
    logic                neg2_s;
    logic [XLEN-1:0]     mag1_s;
    logic [XLEN-1:0]     mag2_s;
    logic [2*XLEN-1:0]   prod_add_s;
    logic [XLEN:0]       rem_shift_s;
    logic [XLEN:0]       rem_trial_s;
    logic [XLEN-1:0]     rem_nxt_s;
    logic [XLEN-1:0]     quo_nxt_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     quo_fix_s;
    logic [XLEN-1:0]     rem_fix_s;
    logic [XLEN-1:0]     final_s;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

    // State register with registered busy/done flags derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_CALC);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand sign decode and magnitude extraction at accept time
    always_comb begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
        case (bus.func3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b1;
            end
            3'b010: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b0;
            end
            3'b011, 3'b101, 3'b111: begin
                op1_signed_s = 1'b0;
                op2_signed_s = 1'b0;
            end
            default: begin
                op1_signed_s = 1'b0;
                op2_signed_s = 1'b0;
            end
        endcase
        neg1_s = op1_signed_s & bus.op1[XLEN-1];
        neg2_s = op2_signed_s & bus.op2[XLEN-1];
        mag1_s = neg1_s ? (XLEN'(0) - bus.op1) : bus.op1;
        mag2_s = neg2_s ? (XLEN'(0) - bus.op2) : bus.op2;
    end

    // One iteration of each datapath plus sign correction of the final value
    always_comb begin
        prod_add_s  = opb_r[0] ? (prod_r + wide_r) : prod_r;
        rem_shift_s = {rem_r, opa_r[XLEN-1]};
        rem_trial_s = rem_shift_s - {1'b0, opb_r};
        // Trial borrow in the top bit means the divisor did not fit: restore
        rem_nxt_s   = rem_trial_s[XLEN] ? rem_shift_s[XLEN-1:0] : rem_trial_s[XLEN-1:0];
        quo_nxt_s   = {opa_r[XLEN-2:0], ~rem_trial_s[XLEN]};
        prod_fix_s  = (neg1_r ^ neg2_r) ? ((2*XLEN)'(0) - prod_add_s) : prod_add_s;
        // A zero divisor must yield all ones regardless of the dividend sign
        quo_fix_s   = ((neg1_r ^ neg2_r) && !div_zero_r) ? (XLEN'(0) - quo_nxt_s) : quo_nxt_s;
        rem_fix_s   = neg1_r ? (XLEN'(0) - rem_nxt_s) : rem_nxt_s;
        final_s     = XLEN'(0);
        case (func3_r)
            3'b000:                 final_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_s = quo_fix_s;
            3'b110, 3'b111:         final_s = rem_fix_s;
            default:                final_s = XLEN'(0);
        endcase
    end

    // Datapath registers: latch on accept, iterate in CALC, write result on last step
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= CNT_W'(0);
            func3_r    <= 3'b000;
            neg1_r     <= 1'b0;
            neg2_r     <= 1'b0;
            div_zero_r <= 1'b0;
            opa_r      <= XLEN'(0);
            opb_r      <= XLEN'(0);
            wide_r     <= (2*XLEN)'(0);
            prod_r     <= (2*XLEN)'(0);
            rem_r      <= XLEN'(0);
            result_r   <= XLEN'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt_r      <= CNT_W'(XLEN);
                        func3_r    <= bus.func3;
                        neg1_r     <= neg1_s;
                        neg2_r     <= neg2_s;
                        div_zero_r <= (bus.op2 == XLEN'(0));
                        opa_r      <= mag1_s;
                        opb_r      <= mag2_s;
                        wide_r     <= {XLEN'(0), mag1_s};
                        prod_r     <= (2*XLEN)'(0);
                        rem_r      <= XLEN'(0);
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (func3_r[2]) begin
                        opa_r <= quo_nxt_s;
                        rem_r <= rem_nxt_s;
                    end else begin
                        prod_r <= prod_add_s;
                        wide_r <= {wide_r[2*XLEN-2:0], 1'b0};
                        opb_r  <= {1'b0, opb_r[XLEN-1:1]};
                    end
                    if (cnt_r == CNT_W'(1)) begin
                        result_r <= final_s;
                    end
                end
                ST_DONE: begin
                    cnt_r <= CNT_W'(0);
                end
                default: begin
                    cnt_r <= CNT_W'(0);
                end
            endcase
        end
    end
endmodule
